// File: rtl/fxp_matmul_seq.sv
// fxp_matmul_seq: sequential Q20.12 matrix product C = A*B, one MAC per cycle.
// Define FXP_MATMUL_SAT_EN to saturate written elements instead of wrapping.
module fxp_matmul_seq #(
  parameter int MAX_DIM = 6,
  parameter int W       = 32,
  parameter int FRAC    = 12
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic [2:0]                   rowsA,
  input  logic [2:0]                   colsA,
  input  logic [2:0]                   colsB,
  input  logic [W*MAX_DIM*MAX_DIM-1:0] Ain,
  input  logic [W*MAX_DIM*MAX_DIM-1:0] Bin,
  output logic [W*MAX_DIM*MAX_DIM-1:0] Cout,
  output logic                         busy,
  output logic                         done,
  output logic                         err
);

  localparam int NE  = MAX_DIM * MAX_DIM;
  localparam int AW  = $clog2(NE);
  localparam int PW  = 2 * W;
  localparam int ACW = 2 * W + 3;
  localparam logic [2:0] MD = 3'(MAX_DIM);

  typedef enum logic [1:0] {IDLE, MAC, WRITE} state_t;

  state_t state;
  state_t state_nx;

  logic [2:0] rows_q;
  logic [2:0] cols_a_q;
  logic [2:0] cols_b_q;
  logic [2:0] i;
  logic [2:0] j;
  logic [2:0] k;

  logic signed [W-1:0] a_m [NE];
  logic signed [W-1:0] b_m [NE];
  logic signed [W-1:0] c_m [NE];

  logic signed [ACW-1:0] acc;
  logic signed [PW-1:0]  prod;
  logic [AW-1:0] a_idx;
  logic [AW-1:0] b_idx;
  logic [AW-1:0] c_idx;
  logic [W-1:0]  wr;

  logic dims_ok;
  logic req;
  logic pend;
  logic last_k;
  logic last_j;
  logic last_i;

  assign dims_ok = (rowsA != 3'd0) && (rowsA <= MD) &&
                   (colsA != 3'd0) && (colsA <= MD) &&
                   (colsB != 3'd0) && (colsB <= MD);

  // an illegal request leaves a one-cycle pending flag before done/err
  assign req = (state == IDLE) && start && !pend;

  assign last_k = (k == cols_a_q - 3'd1);
  assign last_j = (j == cols_b_q - 3'd1);
  assign last_i = (i == rows_q - 3'd1);

  assign a_idx = AW'(i) * AW'(cols_a_q) + AW'(k);
  assign b_idx = AW'(k) * AW'(cols_b_q) + AW'(j);
  assign c_idx = AW'(i) * AW'(cols_b_q) + AW'(j);

  assign prod = PW'(a_m[a_idx]) * PW'(b_m[b_idx]);

`ifdef FXP_MATMUL_SAT_EN
  logic signed [ACW-1:0] sh;
  assign sh = acc >>> FRAC;

  // clamp when the bits above the W-bit sign position disagree
  always_comb begin
    wr = sh[W-1:0];
    if (sh[ACW-1:W-1] != {(ACW-W+1){sh[ACW-1]}}) begin
      wr = sh[ACW-1] ? {1'b1, {(W-1){1'b0}}}
                     : {1'b0, {(W-1){1'b1}}};
    end
  end
`else
  // two's-complement wrap: keep the low W bits of acc >>> FRAC
  always_comb begin
    wr = acc[FRAC +: W];
  end
`endif

  for (genvar g = 0; g < NE; g++) begin : g_out
    assign Cout[g*W +: W] = c_m[g];
  end

  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // next-state logic
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:  if (req && dims_ok) state_nx = MAC;
      MAC:   if (last_k) state_nx = WRITE;
      WRITE: state_nx = (last_i && last_j) ? IDLE : MAC;
      default: state_nx = IDLE;
    endcase
  end

  // operand latch, MAC datapath, result write-back and handshake flags
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rows_q   <= '0;
      cols_a_q <= '0;
      cols_b_q <= '0;
      i        <= '0;
      j        <= '0;
      k        <= '0;
      acc      <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
      pend     <= 1'b0;
      for (int n = 0; n < NE; n++) begin
        a_m[n] <= '0;
        b_m[n] <= '0;
        c_m[n] <= '0;
      end
    end else begin
      done <= pend;
      err  <= pend;
      pend <= 1'b0;
      unique case (state)
        IDLE: begin
          if (req) begin
            for (int n = 0; n < NE; n++) c_m[n] <= '0;
            if (dims_ok) begin
              rows_q   <= rowsA;
              cols_a_q <= colsA;
              cols_b_q <= colsB;
              for (int n = 0; n < NE; n++) begin
                a_m[n] <= Ain[n*W +: W];
                b_m[n] <= Bin[n*W +: W];
              end
              i    <= '0;
              j    <= '0;
              k    <= '0;
              acc  <= '0;
              busy <= 1'b1;
            end else begin
              pend <= 1'b1;
            end
          end
        end
        MAC: begin
          acc <= acc + {{(ACW-PW){prod[PW-1]}}, prod};
          k   <= k + 3'd1;
        end
        WRITE: begin
          c_m[c_idx] <= wr;
          acc        <= '0;
          k          <= '0;
          if (last_j) begin
            j <= '0;
            i <= i + 3'd1;
          end else begin
            j <= j + 3'd1;
          end
          if (last_i && last_j) begin
            done <= 1'b1;
            busy <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fxp_matmul_seq.sv
// tb_fxp_matmul_seq: directed scoreboard bench for fxp_matmul_seq.
// Expected products come from a behavioural Q20.12 reference model.
module tb_fxp_matmul_seq;

  localparam int W  = 32;
  localparam int NE = 36;
  localparam int CW = W * NE;

`ifdef FXP_MATMUL_SAT_EN
  localparam logic [W-1:0] POS_EXP = 32'h7FFFFFFF;
  localparam logic [W-1:0] NEG_EXP = 32'h80000000;
`else
  localparam logic [W-1:0] POS_EXP = 32'h00001000;
  localparam logic [W-1:0] NEG_EXP = 32'h00000000;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [2:0]    rowsA;
  logic [2:0]    colsA;
  logic [2:0]    colsB;
  logic [CW-1:0] Ain;
  logic [CW-1:0] Bin;
  logic [CW-1:0] Cout;
  logic          busy;
  logic          done;
  logic          err;

  int n_asrt = 0;
  int n_fail = 0;

  logic [W-1:0] a_l [NE];
  logic [W-1:0] b_l [NE];

  logic [CW-1:0] q_c[$];
  int            q_lat[$];
  bit            q_err[$];
  string         q_tag[$];

  fxp_matmul_seq dut (
    .clk(clk), .rst(rst), .start(start),
    .rowsA(rowsA), .colsA(colsA), .colsB(colsB),
    .Ain(Ain), .Bin(Bin), .Cout(Cout),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [W-1:0] obs,
                     input logic [W-1:0] exp);
    n_asrt++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic clr_ops();
    for (int n = 0; n < NE; n++) begin
      a_l[n] = '0;
      b_l[n] = '0;
    end
  endtask

  task automatic pack_ops();
    for (int n = 0; n < NE; n++) begin
      Ain[n*W +: W] = a_l[n];
      Bin[n*W +: W] = b_l[n];
    end
  endtask

  function automatic logic [CW-1:0] model(input int r, input int ca,
                                          input int cb);
    logic [CW-1:0]     c;
    logic signed [66:0] s;
    logic signed [66:0] sh;
    logic [W-1:0]      v;
    c = '0;
    for (int i = 0; i < r; i++) begin
      for (int j = 0; j < cb; j++) begin
        s = '0;
        for (int k = 0; k < ca; k++) begin
          s = s + 67'(signed'(a_l[i*ca+k])) * 67'(signed'(b_l[k*cb+j]));
        end
        sh = s >>> 12;
`ifdef FXP_MATMUL_SAT_EN
        if (sh > 67'sd2147483647)       v = 32'h7FFFFFFF;
        else if (sh < -67'sd2147483648) v = 32'h80000000;
        else                            v = sh[W-1:0];
`else
        v = sh[W-1:0];
`endif
        c[(i*cb+j)*W +: W] = v;
      end
    end
    return c;
  endfunction

  task automatic push_exp(input int r, input int ca, input int cb,
                          input string tag);
    bit bad;
    bad = (r < 1) || (r > 6) || (ca < 1) || (ca > 6) ||
          (cb < 1) || (cb > 6);
    q_tag.push_back(tag);
    q_err.push_back(bad);
    q_lat.push_back(bad ? 1 : r * cb * (ca + 1));
    q_c.push_back(bad ? '0 : model(r, ca, cb));
  endtask

  task automatic launch(input int r, input int ca, input int cb,
                        input string tag, input bit hold);
    rowsA = r[2:0];
    colsA = ca[2:0];
    colsB = cb[2:0];
    pack_ops();
    push_exp(r, ca, cb, tag);
    start = 1'b1;
    @(posedge clk);
    #1;
    if (!hold) start = 1'b0;
  endtask

  task automatic wait_done(input int c0);
    int            cnt;
    bit            seen;
    bit            busy_ok;
    string         tag;
    int            lat;
    bit            e;
    logic [CW-1:0] c;
    cnt     = c0;
    seen    = 1'b0;
    busy_ok = 1'b1;
    tag = q_tag.pop_front();
    lat = q_lat.pop_front();
    e   = q_err.pop_front();
    c   = q_c.pop_front();
    while (!seen && cnt < 400) begin
      @(posedge clk);
      #1;
      cnt++;
      if (done) seen = 1'b1;
      else if (!busy) busy_ok = 1'b0;
    end
    chk({tag, " done_seen"}, 32'(seen), 32'd1);
    if (seen) begin
      chk({tag, " latency"}, 32'(cnt), 32'(lat));
      chk({tag, " err"}, 32'(err), 32'(e));
      chk({tag, " busy_at_done"}, 32'(busy), 32'd0);
      if (!e) chk({tag, " busy_during"}, 32'(busy_ok), 32'd1);
      for (int n = 0; n < NE; n++) begin
        chk($sformatf("%s C[%0d]", tag, n), Cout[n*W +: W], c[n*W +: W]);
      end
      @(posedge clk);
      #1;
      chk({tag, " done_one_cycle"}, 32'(done), 32'd0);
      chk({tag, " err_one_cycle"}, 32'(err), 32'd0);
    end
  endtask

  initial begin
    bit early;
    rst   = 1'b1;
    start = 1'b0;
    rowsA = '0;
    colsA = '0;
    colsB = '0;
    Ain   = '0;
    Bin   = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset done", 32'(done), 32'd0);
    chk("reset err", 32'(err), 32'd0);
    chk("reset cout0", Cout[W-1:0], 32'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    clr_ops();
    a_l[0] = 32'h00001800;
    a_l[1] = 32'h00002000;
    a_l[2] = 32'hFFFFF000;
    a_l[3] = 32'h00000800;
    b_l[0] = 32'h00002000;
    b_l[1] = 32'h00004000;
    launch(2, 2, 1, "basic", 1'b0);
    chk("basic busy_after_start", 32'(busy), 32'd1);
    wait_done(0);
    repeat (3) @(posedge clk);
    #1;
    chk("basic c0_hold", Cout[W-1:0], 32'h0000B000);
    chk("basic c1_hold", Cout[2*W-1:W], 32'h00000000);

    launch(2, 0, 2, "illegal_colsA0", 1'b0);
    chk("illegal busy", 32'(busy), 32'd0);
    wait_done(0);

    clr_ops();
    for (int n = 0; n < NE; n++) b_l[n] = $urandom;
    for (int n = 0; n < 6; n++) a_l[n*6+n] = 32'h00001000;
    launch(6, 6, 6, "identity", 1'b0);
    wait_done(0);
    for (int n = 0; n < NE; n++) begin
      chk($sformatf("identity eqB[%0d]", n), Cout[n*W +: W], b_l[n]);
    end

    clr_ops();
    a_l[0] = 32'h7FFFF000;
    b_l[0] = 32'h7FFFF000;
    launch(1, 1, 1, "pos_ovf", 1'b0);
    wait_done(0);
    chk("pos_ovf direct", Cout[W-1:0], POS_EXP);

    clr_ops();
    a_l[0] = 32'h80000000;
    b_l[0] = 32'h00002000;
    launch(1, 1, 1, "neg_ovf", 1'b0);
    wait_done(0);
    chk("neg_ovf direct", Cout[W-1:0], NEG_EXP);

    clr_ops();
    a_l[0] = 32'h00001800;
    a_l[1] = 32'h00002000;
    a_l[2] = 32'hFFFFF000;
    a_l[3] = 32'h00000800;
    b_l[0] = 32'h00002000;
    b_l[1] = 32'h00004000;
    launch(2, 2, 1, "mid_start", 1'b0);
    @(posedge clk);
    #1;
    for (int n = 0; n < NE; n++) begin
      a_l[n] = 32'h00003000;
      b_l[n] = 32'hFFFFE000;
    end
    pack_ops();
    colsB = 3'd2;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done(2);

    clr_ops();
    a_l[0] = 32'h00001000;
    b_l[0] = 32'h00003000;
    launch(1, 1, 1, "hold_first", 1'b1);
    a_l[0] = 32'h00002000;
    pack_ops();
    push_exp(1, 1, 1, "hold_second");
    wait_done(0);
    chk("hold restart busy", 32'(busy), 32'd1);
    start = 1'b0;
    wait_done(0);

    clr_ops();
    for (int n = 0; n < NE; n++) begin
      a_l[n] = 32'h00001000 + 32'(n);
      b_l[n] = 32'h00002000 - 32'(n);
    end
    launch(6, 6, 6, "abort", 1'b0);
    early = 1'b0;
    repeat (10) begin
      @(posedge clk);
      #1;
      if (done) early = 1'b1;
    end
    chk("abort partial_written", 32'(Cout[W-1:0] != 0), 32'd1);
    rst = 1'b1;
    #1;
    chk("abort cout0", Cout[W-1:0], 32'd0);
    chk("abort busy", 32'(busy), 32'd0);
    repeat (3) begin
      @(posedge clk);
      #1;
      if (done) early = 1'b1;
    end
    chk("abort no_done", 32'(early), 32'd0);
    for (int n = 0; n < NE; n++) begin
      chk($sformatf("abort C[%0d]", n), Cout[n*W +: W], 32'd0);
    end
    void'(q_tag.pop_front());
    void'(q_lat.pop_front());
    void'(q_err.pop_front());
    void'(q_c.pop_front());
    rst = 1'b0;
    @(posedge clk);
    #1;

    clr_ops();
    a_l[0] = 32'h00001000;
    a_l[1] = 32'h00002000;
    a_l[2] = 32'hFFFFD000;
    a_l[3] = 32'h00000400;
    b_l[0] = 32'h00000800;
    b_l[1] = 32'hFFFFF000;
    b_l[2] = 32'h00003000;
    b_l[3] = 32'h00001000;
    launch(2, 2, 2, "post_reset", 1'b0);
    wait_done(0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_asrt, n_fail);
    $finish;
  end

endmodule
